fetch_pc_stage: RTL and testbench
=================================

Name: fetch_pc_stage

Overview:
- Instruction-fetch stage.
- Owns the 64-bit program-counter register, which drives the PC+4 adder and instruction memory.
- Takes the adder result back as its sequential next PC. Applies hazard-unit stall and EX-stage branch/jump redirect.
- Captures the fetched instruction into the IF/ID pipeline register, and keeps saturating fetch and stall performance counters.

Parameters:
- RESET_VECTOR, 64'h0000_0000_0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted on flush/reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- pc_plus4_i  in  64  sequential next PC from the PC+4 adder (= pc_o + 4).
- stall_i  in  1  hazard-unit stall; freezes PC and IF/ID.
- redirect_i  in  1  EX-stage taken branch/jump.
- redirect_target_i  in  64  redirect destination.
- instr_i  in  32  instruction memory read data for address pc_o (combinational, same cycle).
- pc_o  out  64  current PC; feeds the adder and imem address.
- if_id_pc_o  out  64  PC of the instruction held in IF/ID.
- if_id_pc_plus4_o  out  64  link address of the instruction held in IF/ID.
- if_id_instr_o  out  32  instruction held in IF/ID.
- if_id_valid_o  out  1  IF/ID holds a real instruction.
- misalign_o  out  1  one-cycle pulse: last accepted redirect target had bits[1:0] != 0.
- fetch_cnt_o  out  32  count of valid instructions loaded into IF/ID, saturating.
- stall_cnt_o  out  32  count of RUN cycles frozen by stall, saturating.

Behaviour:
- All state updates on the rising edge of clk. rst_n is sampled only at the edge.
- Reset (rst_n=0 at edge) loads:
  - pc_o=RESET_VECTOR, if_id_pc_o=0, if_id_pc_plus4_o=0, if_id_instr_o=NOP_INSTR.
  - if_id_valid_o=0, misalign_o=0, fetch_cnt_o=0, stall_cnt_o=0.
  - state=BOOT.
- Reset asserted mid-operation overrides everything else, including redirect and stall.
- State machine, two states:
  - BOOT: one cycle after reset release. PC is held and IF/ID stays a bubble (valid=0). stall_i and redirect_i are ignored, since no EX instruction exists yet. Unconditional transition to RUN.
  - RUN: stays in RUN until reset.
- RUN priority is redirect > stall > normal.
- Redirect (redirect_i=1), whether or not stall_i is set:
  - pc_o <= {redirect_target_i[63:2],2'b00}.
  - IF/ID flushed: instr=NOP_INSTR, valid=0; pc fields loaded with 0.
  - misalign_o <= |redirect_target_i[1:0]. stall_cnt_o does not increment.
- Stall (redirect_i=0, stall_i=1):
  - pc_o and all IF/ID fields hold.
  - misalign_o <= 0.
  - stall_cnt_o += 1, saturating.
- Normal (redirect_i=0, stall_i=0):
  - pc_o <= pc_plus4_i.
  - if_id_pc_o <= pc_o, if_id_pc_plus4_o <= pc_plus4_i, if_id_instr_o <= instr_i, if_id_valid_o <= 1.
  - fetch_cnt_o += 1, saturating. misalign_o <= 0.
- pc_plus4_i is used as-is. 64-bit wrap from FFFF_FFFF_FFFF_FFFC to 0 is legal and not flagged.
- Counters saturate at 32'hFFFF_FFFF and never wrap.
- Latency: an instruction at PC p appears in IF/ID one edge after pc_o=p in an unstalled cycle. A redirect target appears on pc_o one edge after the redirect, and its instruction reaches IF/ID one edge after that, giving exactly one bubble.
- No combinational path from any input to any output. All outputs are registered.

Test Plan:
- Reset, then release with RESET_VECTOR=0x1000 and no stall: pc_o is 0x1000 for two edges (reset plus BOOT), then 0x1004, 0x1008. IF/ID gets {0x1000, 0x1004, instr}, valid=1, on the edge after BOOT. fetch_cnt_o=1.
- Assert stall_i for 3 cycles at pc_o=0x1008: pc_o and IF/ID are frozen for 3 cycles, stall_cnt_o=3, fetch_cnt_o unchanged. On release, pc_o goes to 0x100C.
- Redirect to 0x2000 with stall_i=1 in the same cycle: pc_o=0x2000 next edge, IF/ID is NOP with valid=0, stall_cnt_o not incremented. The next unstalled edge loads IF/ID with pc 0x2000 and valid=1.
- Redirect to 0x2002: pc_o=0x2000, misalign_o=1 for exactly one cycle, then 0.
- redirect_i=1 during the BOOT cycle: ignored, and pc_o stays RESET_VECTOR. Reset asserted while a redirect is pending: reset values win.
- Preload near saturation (force fetch_cnt_o=32'hFFFF_FFFE), run 3 normal cycles: the count reaches FFFF_FFFF and holds. pc_o=FFFF_FFFF_FFFF_FFFC with pc_plus4_i=0: pc_o wraps to 0.

Source files
------------

// File: rtl/fetch_pc_stage.sv
// Instruction-fetch stage: PC register, stall/redirect handling, IF/ID pipeline
// register and saturating fetch/stall performance counters.
module fetch_pc_stage #(
  parameter logic [63:0] RESET_VECTOR = 64'h0000_0000_0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] pc_plus4_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_target_i,
  input  logic [31:0] instr_i,
  output logic [63:0] pc_o,
  output logic [63:0] if_id_pc_o,
  output logic [63:0] if_id_pc_plus4_o,
  output logic [31:0] if_id_instr_o,
  output logic        if_id_valid_o,
  output logic        misalign_o,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic {BOOT, RUN} state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] if_id_pc_q, if_id_pc_d;
  logic [63:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= BOOT;
      pc_q             <= RESET_VECTOR;
      if_id_pc_q       <= 64'd0;
      if_id_pc_plus4_q <= 64'd0;
      if_id_instr_q    <= NOP_INSTR;
      if_id_valid_q    <= 1'b0;
      misalign_q       <= 1'b0;
      fetch_cnt_q      <= 32'd0;
      stall_cnt_q      <= 32'd0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      if_id_pc_q       <= if_id_pc_d;
      if_id_pc_plus4_q <= if_id_pc_plus4_d;
      if_id_instr_q    <= if_id_instr_d;
      if_id_valid_q    <= if_id_valid_d;
      misalign_q       <= misalign_d;
      fetch_cnt_q      <= fetch_cnt_d;
      stall_cnt_q      <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    if_id_pc_d       = if_id_pc_q;
    if_id_pc_plus4_d = if_id_pc_plus4_q;
    if_id_instr_d    = if_id_instr_q;
    if_id_valid_d    = if_id_valid_q;
    misalign_d       = 1'b0;
    fetch_cnt_d      = fetch_cnt_q;
    stall_cnt_d      = stall_cnt_q;

    unique case (state_q)
      // No EX instruction exists yet, so stall/redirect are meaningless here.
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect_i) begin
          pc_d             = {redirect_target_i[63:2], 2'b00};
          if_id_pc_d       = 64'd0;
          if_id_pc_plus4_d = 64'd0;
          if_id_instr_d    = NOP_INSTR;
          if_id_valid_d    = 1'b0;
          misalign_d       = |redirect_target_i[1:0];
        end else if (stall_i) begin
          if (stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
          pc_d             = pc_plus4_i;
          if_id_pc_d       = pc_q;
          if_id_pc_plus4_d = pc_plus4_i;
          if_id_instr_d    = instr_i;
          if_id_valid_d    = 1'b1;
          if (fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign pc_o             = pc_q;
  assign if_id_pc_o       = if_id_pc_q;
  assign if_id_pc_plus4_o = if_id_pc_plus4_q;
  assign if_id_instr_o    = if_id_instr_q;
  assign if_id_valid_o    = if_id_valid_q;
  assign misalign_o       = misalign_q;
  assign fetch_cnt_o      = fetch_cnt_q;
  assign stall_cnt_o      = stall_cnt_q;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Directed bench for fetch_pc_stage: reset/BOOT, stall, redirect, misalign,
// counter saturation and 64-bit PC wrap.
module tb_fetch_pc_stage;

  localparam logic [63:0] RV  = 64'h0000_0000_0000_1000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] pc_plus4_i;
  logic        stall_i;
  logic        redirect_i;
  logic [63:0] redirect_target_i;
  logic [31:0] instr_i;
  logic [63:0] pc_o, if_id_pc_o, if_id_pc_plus4_o;
  logic [31:0] if_id_instr_o, fetch_cnt_o, stall_cnt_o;
  logic        if_id_valid_o, misalign_o;

  int vectors = 0;
  int miscompares = 0;

  fetch_pc_stage #(.RESET_VECTOR(RV), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .pc_plus4_i(pc_plus4_i), .stall_i(stall_i),
    .redirect_i(redirect_i), .redirect_target_i(redirect_target_i),
    .instr_i(instr_i), .pc_o(pc_o), .if_id_pc_o(if_id_pc_o),
    .if_id_pc_plus4_o(if_id_pc_plus4_o), .if_id_instr_o(if_id_instr_o),
    .if_id_valid_o(if_id_valid_o), .misalign_o(misalign_o),
    .fetch_cnt_o(fetch_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  // External PC+4 adder and a recognisable per-address instruction memory.
  assign pc_plus4_i = pc_o + 64'd4;
  assign instr_i    = pc_o[31:0] ^ 32'hA5A5_0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [63:0] pc, input logic [63:0] p4,
                          input logic [31:0] ins, input logic v);
    chk({tag, "_ifid_pc"}, if_id_pc_o, pc);
    chk({tag, "_ifid_p4"}, if_id_pc_plus4_o, p4);
    chk({tag, "_ifid_instr"}, {32'd0, if_id_instr_o}, {32'd0, ins});
    chk({tag, "_ifid_valid"}, {63'd0, if_id_valid_o}, {63'd0, v});
  endtask

  initial begin
    // Reset with a pending redirect and stall: reset wins.
    rst_n = 1'b0; stall_i = 1'b1; redirect_i = 1'b1; redirect_target_i = 64'h5554;
    tick(); tick();
    chk("rst_pc", pc_o, RV);
    chk_ifid("rst", 64'd0, 64'd0, NOP, 1'b0);
    chk("rst_mis", {63'd0, misalign_o}, 64'd0);
    chk("rst_fcnt", {32'd0, fetch_cnt_o}, 64'd0);
    chk("rst_scnt", {32'd0, stall_cnt_o}, 64'd0);

    // BOOT cycle ignores redirect.
    rst_n = 1'b1; stall_i = 1'b0; redirect_i = 1'b1; redirect_target_i = 64'h3000;
    tick();
    chk("boot_pc", pc_o, RV);
    chk("boot_valid", {63'd0, if_id_valid_o}, 64'd0);
    redirect_i = 1'b0;

    tick();
    chk("run1_pc", pc_o, 64'h1004);
    chk_ifid("run1", 64'h1000, 64'h1004, 32'hA5A5_1000, 1'b1);
    chk("run1_fcnt", {32'd0, fetch_cnt_o}, 64'd1);
    tick();
    chk("run2_pc", pc_o, 64'h1008);
    chk("run2_fcnt", {32'd0, fetch_cnt_o}, 64'd2);

    // Three stalled cycles freeze PC and IF/ID.
    stall_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("stall_pc", pc_o, 64'h1008);
      chk_ifid("stall", 64'h1004, 64'h1008, 32'hA5A5_1004, 1'b1);
      chk("stall_scnt", {32'd0, stall_cnt_o}, 64'(i));
      chk("stall_fcnt", {32'd0, fetch_cnt_o}, 64'd2);
    end
    stall_i = 1'b0;
    tick();
    chk("unstall_pc", pc_o, 64'h100C);
    chk_ifid("unstall", 64'h1008, 64'h100C, 32'hA5A5_1008, 1'b1);
    chk("unstall_fcnt", {32'd0, fetch_cnt_o}, 64'd3);

    // Redirect beats a simultaneous stall and flushes IF/ID.
    redirect_i = 1'b1; stall_i = 1'b1; redirect_target_i = 64'h2000;
    tick();
    chk("redir_pc", pc_o, 64'h2000);
    chk_ifid("redir", 64'd0, 64'd0, NOP, 1'b0);
    chk("redir_scnt", {32'd0, stall_cnt_o}, 64'd3);
    chk("redir_fcnt", {32'd0, fetch_cnt_o}, 64'd3);
    chk("redir_mis", {63'd0, misalign_o}, 64'd0);
    redirect_i = 1'b0; stall_i = 1'b0;
    tick();
    chk("post_redir_pc", pc_o, 64'h2004);
    chk_ifid("post_redir", 64'h2000, 64'h2004, 32'hA5A5_2000, 1'b1);
    chk("post_redir_fcnt", {32'd0, fetch_cnt_o}, 64'd4);

    // Misaligned target is aligned and flagged for one cycle.
    redirect_i = 1'b1; redirect_target_i = 64'h2002;
    tick();
    chk("mis_pc", pc_o, 64'h2000);
    chk("mis_flag", {63'd0, misalign_o}, 64'd1);
    redirect_i = 1'b0;
    tick();
    chk("mis_clear", {63'd0, misalign_o}, 64'd0);
    chk("mis_next_pc", pc_o, 64'h2004);
    chk("mis_fcnt", {32'd0, fetch_cnt_o}, 64'd5);

    // 64-bit PC wrap.
    redirect_i = 1'b1; redirect_target_i = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    chk("wrap_pre_pc", pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
    redirect_i = 1'b0;
    tick();
    chk("wrap_pc", pc_o, 64'd0);
    chk_ifid("wrap", 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 32'h5A5A_FFFC, 1'b1);
    chk("wrap_mis", {63'd0, misalign_o}, 64'd0);

    // Fetch counter saturation.
    force dut.fetch_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.fetch_cnt_q;
    tick();
    chk("sat1", {32'd0, fetch_cnt_o}, 64'hFFFF_FFFF);
    tick();
    chk("sat2", {32'd0, fetch_cnt_o}, 64'hFFFF_FFFF);
    tick();
    chk("sat3", {32'd0, fetch_cnt_o}, 64'hFFFF_FFFF);

    // Mid-run reset with a pending redirect.
    rst_n = 1'b0; redirect_i = 1'b1; redirect_target_i = 64'h4000;
    tick();
    chk("mrst_pc", pc_o, RV);
    chk_ifid("mrst", 64'd0, 64'd0, NOP, 1'b0);
    chk("mrst_fcnt", {32'd0, fetch_cnt_o}, 64'd0);
    chk("mrst_scnt", {32'd0, stall_cnt_o}, 64'd0);
    chk("mrst_mis", {63'd0, misalign_o}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
